// File: rtl/mest_pro_display_scan.sv
// -----------------------------------------------------------------------------
// mest_pro_display_scan
//
// Multiplexed 7-segment scanner that sits after the MEST Pro output decoder.
// Decoded segment words are written into a per-digit buffer. The scanner walks
// digits 0..NUM_DIGITS-1. Each digit slot is BLANK_CYCLES all-dark cycles,
// which suppress ghosting, followed by REFRESH_DIV cycles with that digit's
// anode selected and its pattern on the shared segment bus.
//
// Ports
//   clk           system clock, all state on rising edge
//   rst           asynchronous active-high reset
//   i_wr_en       buffer write strobe
//   i_wr_digit    target digit of the write; out-of-range indices are dropped
//   i_seg         segment pattern to store (1 = segment lit)
//   i_enable      scan enable; low forces the display dark and parks the scan
//   o_seg         registered segment bus (1 = lit)
//   o_anode       registered digit selects, polarity set by ANODE_ACTIVE_LOW
//   o_digit_idx   digit whose slot (blank or show) is currently on the pins
//   o_frame_done  one-cycle pulse on the first cycle of each new frame
//
// All outputs are registered from the current state and buffer contents.
// They therefore trail the internal state by one cycle. As a result, a buffer
// write reaches the pins one edge after it lands. A slot that starts on the
// same edge as a write shows the updated pattern.
// -----------------------------------------------------------------------------
`ifndef OUTPUT_MEM_WIDTH
`define OUTPUT_MEM_WIDTH 7
`endif

module mest_pro_display_scan #(
    parameter int NUM_DIGITS       = 4,
    parameter int SEG_WIDTH        = `OUTPUT_MEM_WIDTH,
    parameter int REFRESH_DIV      = 1000,
    parameter int BLANK_CYCLES     = 16,
    parameter int ANODE_ACTIVE_LOW = 1,
    localparam int IDX_W           = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_digit,
    input  logic [SEG_WIDTH-1:0]  i_seg,
    input  logic                  i_enable,
    output logic [SEG_WIDTH-1:0]  o_seg,
    output logic [NUM_DIGITS-1:0] o_anode,
    output logic [IDX_W-1:0]      o_digit_idx,
    output logic                  o_frame_done
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]      REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST   = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [IDX_W-1:0]      IDX_LAST     = IDX_W'(NUM_DIGITS - 1);
    localparam logic                  HAS_BLANK    = (BLANK_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] ANODE_IDLE   = (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                             : {NUM_DIGITS{1'b0}};

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [SEG_WIDTH-1:0]  buf_q [NUM_DIGITS];

    logic [SEG_WIDTH-1:0]  o_seg_q;
    logic [NUM_DIGITS-1:0] o_anode_q;
    logic [IDX_W-1:0]      o_digit_idx_q;
    logic                  o_frame_done_q;

    logic [SEG_WIDTH-1:0]  sel_seg_s;
    logic [NUM_DIGITS-1:0] sel_onehot_s;
    logic [SEG_WIDTH-1:0]  seg_d;
    logic [NUM_DIGITS-1:0] anode_d;
    logic                  frame_d;

    // Digit buffer: one register per digit. Indices at or above NUM_DIGITS match no entry, so the write is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                buf_q[i] <= {SEG_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (i_wr_en && (i_wr_digit == IDX_W'(i))) begin
                    buf_q[i] <= i_seg;
                end
            end
        end
    end

    // Select the current digit's pattern and anode, and build the next registered output values.
    always_comb begin
        sel_seg_s    = {SEG_WIDTH{1'b0}};
        sel_onehot_s = {NUM_DIGITS{1'b0}};
        seg_d        = {SEG_WIDTH{1'b0}};
        anode_d      = ANODE_IDLE;
        frame_d      = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_onehot_s[i] = (idx_q == IDX_W'(i));
            sel_seg_s       = sel_seg_s | (buf_q[i] & {SEG_WIDTH{(idx_q == IDX_W'(i))}});
        end
        // Enable is gated here so the pins go dark on the edge that samples it low.
        if (i_enable && (state_q == ST_SHOW)) begin
            seg_d   = sel_seg_s;
            anode_d = (ANODE_ACTIVE_LOW != 0) ? ~sel_onehot_s : sel_onehot_s;
        end else begin
            seg_d   = {SEG_WIDTH{1'b0}};
            anode_d = ANODE_IDLE;
        end
        // A frame starts when the index has just wrapped from the last digit to 0.
        // The pins still show the last digit at that point. The scan index is held
        // while disabled, and it is 0 both out of reset and on the pins, so neither
        // the first frame after reset nor the first frame after re-enable is flagged.
        frame_d = (idx_q == {IDX_W{1'b0}}) && (o_digit_idx_q == IDX_LAST);
    end

    // Scan FSM, slot counter, digit index and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_BLANK;
            cnt_q          <= {CNT_W{1'b0}};
            idx_q          <= {IDX_W{1'b0}};
            o_seg_q        <= {SEG_WIDTH{1'b0}};
            o_anode_q      <= ANODE_IDLE;
            o_digit_idx_q  <= {IDX_W{1'b0}};
            o_frame_done_q <= 1'b0;
        end else begin
            o_seg_q        <= seg_d;
            o_anode_q      <= anode_d;
            o_digit_idx_q  <= idx_q;
            o_frame_done_q <= frame_d;
            if (!i_enable) begin
                // Park in a fresh blank slot of the same digit.
                state_q <= ST_BLANK;
                cnt_q   <= {CNT_W{1'b0}};
            end else begin
                case (state_q)
                    ST_BLANK: begin
                        // With no blank time this state is only entered from reset or disable; leave it at once.
                        if (!HAS_BLANK || (cnt_q == BLANK_LAST)) begin
                            state_q <= ST_SHOW;
                            cnt_q   <= {CNT_W{1'b0}};
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_SHOW: begin
                        if (cnt_q == REFRESH_LAST) begin
                            cnt_q   <= {CNT_W{1'b0}};
                            idx_q   <= (idx_q == IDX_LAST) ? {IDX_W{1'b0}} : (idx_q + IDX_W'(1));
                            state_q <= HAS_BLANK ? ST_BLANK : ST_SHOW;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_BLANK;
                        cnt_q   <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    assign o_seg        = o_seg_q;
    assign o_anode      = o_anode_q;
    assign o_digit_idx  = o_digit_idx_q;
    assign o_frame_done = o_frame_done_q;

endmodule

// File: tb/tb_mest_pro_display_scan.sv
// -----------------------------------------------------------------------------
// Bench for mest_pro_display_scan. Three instances are used:
//   dut0: 4 digits, 4 show cycles, 2 blank cycles (main scan, live update,
//         enable drop, reset)
//   dut1: 3 digits, same timing, with its own write port (out-of-range write)
//   dut2: 4 digits, 4 show cycles, no blanking
// Expected values come from hand-written tables.
// -----------------------------------------------------------------------------
module tb_mest_pro_display_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, wr1_en;
    logic [1:0] wr_digit, wr1_digit;
    logic [6:0] wr_seg, wr1_seg;
    logic       enable;

    logic [6:0] seg0, seg1, seg2;
    logic [3:0] an0, an2;
    logic [2:0] an1;
    logic [1:0] idx0, idx1, idx2;
    logic       fd0, fd1, fd2;

    always #5 clk = ~clk;

    mest_pro_display_scan #(.NUM_DIGITS(4), .SEG_WIDTH(7), .REFRESH_DIV(4), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1)) dut0 (
        .clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_digit(wr_digit), .i_seg(wr_seg), .i_enable(enable),
        .o_seg(seg0), .o_anode(an0), .o_digit_idx(idx0), .o_frame_done(fd0));

    mest_pro_display_scan #(.NUM_DIGITS(3), .SEG_WIDTH(7), .REFRESH_DIV(4), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1)) dut1 (
        .clk(clk), .rst(rst), .i_wr_en(wr1_en), .i_wr_digit(wr1_digit), .i_seg(wr1_seg), .i_enable(enable),
        .o_seg(seg1), .o_anode(an1), .o_digit_idx(idx1), .o_frame_done(fd1));

    mest_pro_display_scan #(.NUM_DIGITS(4), .SEG_WIDTH(7), .REFRESH_DIV(4), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_digit(wr_digit), .i_seg(wr_seg), .i_enable(enable),
        .o_seg(seg2), .o_anode(an2), .o_digit_idx(idx2), .o_frame_done(fd2));

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] idx;
    } vec_t;

    vec_t       tbl [24];
    vec_t       drop_tbl [9];
    logic [6:0] pat [4];
    logic [3:0] an_show [4];
    logic [2:0] an1_show [3];

    int errs = 0;
    int checks = 0;

    int   p, p1, d1, s1, p2, d2;
    logic found;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Hand-computed frame table for dut0: 2 blank + 4 show per digit
        pat      = '{7'h7E, 7'h30, 7'h6D, 7'h79};
        an_show  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        an1_show = '{3'b110, 3'b101, 3'b011};
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 6; s++) begin
                tbl[d*6+s].idx = 2'(d);
                tbl[d*6+s].an  = (s < 2) ? 4'b1111 : an_show[d];
                tbl[d*6+s].seg = (s < 2) ? 7'h00 : pat[d];
            end
        end
        // After re-enable on digit 2: 2 blank, 4 show, then digit 3 blank, blank, show
        drop_tbl = '{
            '{4'b1111, 7'h00, 2'd2}, '{4'b1111, 7'h00, 2'd2},
            '{4'b1011, 7'h6D, 2'd2}, '{4'b1011, 7'h6D, 2'd2},
            '{4'b1011, 7'h6D, 2'd2}, '{4'b1011, 7'h6D, 2'd2},
            '{4'b1111, 7'h00, 2'd3}, '{4'b1111, 7'h00, 2'd3},
            '{4'b0111, 7'h79, 2'd3}};

        rst = 1'b1; enable = 1'b0;
        wr_en = 1'b0; wr_digit = 2'd0; wr_seg = 7'h00;
        wr1_en = 1'b0; wr1_digit = 2'd0; wr1_seg = 7'h00;
        repeat (3) step();
        rst = 1'b0;

        check("rst_anode", 32'(an0), 32'(4'b1111));
        check("rst_seg", 32'(seg0), 32'(7'h00));
        check("rst_idx", 32'(idx0), 32'(2'd0));
        check("rst_fd", 32'(fd0), 32'(1'b0));
        check("rst_anode_n3", 32'(an1), 32'(3'b111));

        // Load buffers; dut1 gets 7F on out-of-range digit 3
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1; wr_digit = 2'(k); wr_seg = pat[k];
            wr1_en = 1'b1; wr1_digit = 2'(k); wr1_seg = (k == 3) ? 7'h7F : pat[k];
            step();
        end
        wr_en = 1'b0; wr1_en = 1'b0;
        check("dark_while_disabled", 32'(an0), 32'(4'b1111));
        enable = 1'b1;

        // Two frames of scan on all three instances
        for (int c = 0; c < 48; c++) begin
            step();
            p = c % 24;
            check("scan_anode", 32'(an0), 32'(tbl[p].an));
            check("scan_seg", 32'(seg0), 32'(tbl[p].seg));
            check("scan_idx", 32'(idx0), 32'(tbl[p].idx));
            check("scan_frame", 32'(fd0), 32'((p == 0) && (c >= 24)));

            p1 = c % 18; d1 = p1 / 6; s1 = p1 % 6;
            check("n3_anode", 32'(an1), 32'((s1 < 2) ? 3'b111 : an1_show[d1]));
            check("n3_seg", 32'(seg1), 32'((s1 < 2) ? 7'h00 : pat[d1]));
            check("n3_idx", 32'(idx1), 32'(d1));
            check("n3_frame", 32'(fd1), 32'((p1 == 0) && (c >= 18)));

            if (c == 0) begin
                check("nb_first_dark", 32'(an2), 32'(4'b1111));
            end else begin
                p2 = (c - 1) % 16; d2 = p2 / 4;
                check("nb_anode", 32'(an2), 32'(an_show[d2]));
                check("nb_seg", 32'(seg2), 32'(pat[d2]));
                check("nb_idx", 32'(idx2), 32'(d2));
                check("nb_frame", 32'(fd2), 32'((p2 == 0) && (c > 16)));
            end
        end

        // Advance to first show cycle of digit 1 (p = 8)
        for (int c = 48; c <= 56; c++) begin
            step();
            check("pre_live_anode", 32'(an0), 32'(tbl[c % 24].an));
        end
        // Live update of the showing digit
        wr_en = 1'b1; wr_digit = 2'd1; wr_seg = 7'h33;
        step();
        wr_en = 1'b0;
        check("live_k_seg", 32'(seg0), 32'(7'h30));
        check("live_k_anode", 32'(an0), 32'(4'b1101));
        step();
        check("live_k1_seg", 32'(seg0), 32'(7'h33));
        check("live_k1_anode", 32'(an0), 32'(4'b1101));
        step();
        check("live_k2_seg", 32'(seg0), 32'(7'h33));
        step();
        check("live_slot_end", 32'(an0), 32'(4'b1111));
        check("live_slot_end_idx", 32'(idx0), 32'(2'd2));

        // Up to second show cycle of digit 2 (p = 13..15)
        for (int c = 61; c <= 63; c++) begin
            step();
            check("pre_drop_anode", 32'(an0), 32'(tbl[c % 24].an));
            check("pre_drop_seg", 32'(seg0), 32'(tbl[c % 24].seg));
        end
        enable = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            check("drop_anode", 32'(an0), 32'(4'b1111));
            check("drop_seg", 32'(seg0), 32'(7'h00));
            check("drop_idx", 32'(idx0), 32'(2'd2));
        end
        enable = 1'b1;
        for (int j = 0; j < 9; j++) begin
            step();
            check("reen_anode", 32'(an0), 32'(drop_tbl[j].an));
            check("reen_seg", 32'(seg0), 32'(drop_tbl[j].seg));
            check("reen_idx", 32'(idx0), 32'(drop_tbl[j].idx));
            check("reen_frame", 32'(fd0), 32'(1'b0));
        end

        // Find the next show of digit 2, then reset mid-cycle
        found = 1'b0;
        for (int j = 0; j < 40 && !found; j++) begin
            step();
            if (an0 == 4'b1011) found = 1'b1;
        end
        check("wait_digit2", 32'(found), 32'(1'b1));
        #2;
        rst = 1'b1;
        wr_en = 1'b1; wr_digit = 2'd0; wr_seg = 7'h7F;
        #1;
        check("async_rst_anode", 32'(an0), 32'(4'b1111));
        check("async_rst_seg", 32'(seg0), 32'(7'h00));
        check("async_rst_idx", 32'(idx0), 32'(2'd0));
        check("async_rst_frame", 32'(fd0), 32'(1'b0));
        step();
        rst = 1'b0;
        wr_en = 1'b0;

        // Buffer cleared: scan runs with all-zero segments, no frame pulse in first frame
        for (int c = 0; c < 24; c++) begin
            step();
            check("post_rst_anode", 32'(an0), 32'(tbl[c].an));
            check("post_rst_seg", 32'(seg0), 32'(7'h00));
            check("post_rst_idx", 32'(idx0), 32'(tbl[c].idx));
            check("post_rst_frame", 32'(fd0), 32'(1'b0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mest_pro_display_scan.md
Name: mest_pro_display_scan

Overview:
- Downstream consumer of the 7-segment output decoder. Takes decoded segment patterns (the decoder's `o_display` word) into a per-digit buffer.
- Time-multiplexes the buffer onto a shared segment bus plus one anode line per digit.
- Inserts blanking between digits to suppress ghosting. Raises a one-cycle frame marker each full scan.
- Sits between the MEST Pro output decoder and the board's LED pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (>=2).
- SEG_WIDTH, `OUTPUT_MEM_WIDTH (7), segment word width; bit order/polarity identical to decoder output (1 = segment lit).
- REFRESH_DIV, 1000, clock cycles each digit is shown per frame (>=1).
- BLANK_CYCLES, 16, all-off clock cycles before each digit slot (>=0).
- ANODE_ACTIVE_LOW, 1, 1: selected anode driven 0; 0: selected anode driven 1.
- IDX_W (localparam), clog2(NUM_DIGITS), digit index width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_wr_en  input  1  write strobe; buffer write on a clk edge where high.
- i_wr_digit  input  IDX_W  target digit index for write.
- i_seg  input  SEG_WIDTH  segment pattern to store (from decoder o_display).
- i_enable  input  1  scan enable; low forces display dark.
- o_seg  output  SEG_WIDTH  registered segment bus, 1 = lit.
- o_anode  output  NUM_DIGITS  registered digit selects, polarity per ANODE_ACTIVE_LOW.
- o_digit_idx  output  IDX_W  index of digit currently in its slot (blank or show).
- o_frame_done  output  1  one-cycle pulse at start of each new frame.

Behaviour:
- Reset (async, immediate on rst high, no clock needed):
  - o_seg = 0; o_anode = all inactive (all 1s when ANODE_ACTIVE_LOW = 1); o_digit_idx = 0; o_frame_done = 0.
  - All buffer entries = 0; state = BLANK; counter = 0.
- Buffer:
  - NUM_DIGITS x SEG_WIDTH registers. On edge with i_wr_en=1 and i_wr_digit < NUM_DIGITS: buf[i_wr_digit] <= i_seg.
  - Index >= NUM_DIGITS: write dropped, no state change.
  - Writes are accepted regardless of i_enable or FSM state.
- FSM states: BLANK, SHOW.
  - BLANK: o_anode all inactive, o_seg = 0. Lasts exactly BLANK_CYCLES cycles, then SHOW.
  - If BLANK_CYCLES = 0, BLANK is skipped and SHOW follows SHOW directly.
  - SHOW: o_anode[idx] active, others inactive; o_seg = buf[idx]. Lasts exactly REFRESH_DIV cycles.
  - End of SHOW: idx <= idx+1, wrapping NUM_DIGITS-1 -> 0; next state is BLANK (or SHOW when BLANK_CYCLES = 0).
  - Frame period = NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles. Scan order is 0,1,...,NUM_DIGITS-1.
- Counter:
  - Width clog2(max(REFRESH_DIV, BLANK_CYCLES)+1); reloads to 0 on every state or digit change.
  - No overflow is possible within legal parameters.
- Outputs are registered.
  - o_seg/o_anode during SHOW follow buf[idx] with one-cycle latency.
  - A write sampled at edge k to the digit currently showing is visible on o_seg after edge k+1.
  - No partial or torn pattern ever appears.
- o_frame_done: high for exactly one cycle, the first cycle of digit 0's slot after digit NUM_DIGITS-1 finishes SHOW. Not asserted for the first frame after reset or after re-enable.
- i_enable:
  - Sampled every edge. When low: state forced to BLANK, counter held at 0, idx held, o_seg = 0, anodes inactive from next cycle.
  - On re-assert: a full BLANK period runs, then SHOW of the held idx for a full REFRESH_DIV.
  - Dropping i_enable mid-SHOW does not advance idx.
- Simultaneous events:
  - Write plus slot change on the same edge: the write lands; the new slot reads the updated buffer.
  - rst overrides everything, including i_wr_en.
- No state beyond the buffer, FSM, counter and idx. No combinational path from inputs to outputs.

Test Plan:
- Reset, using NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2: assert rst mid-SHOW of digit 2 -> o_anode=4'b1111, o_seg=0, o_digit_idx=0 before the next clk edge. Buffer reads 0 after release.
- Scan order: write 7'h7E,7'h30,7'h6D,7'h79 to digits 0..3, then i_enable=1 -> repeating pattern:
  - 2 cycles (1111, 0); 4 cycles (1110, 7E).
  - 2 blank; 4 cycles (1101, 30).
  - 2 blank; 4 cycles (1011, 6D).
  - 2 blank; 4 cycles (0111, 79).
  - o_frame_done pulses every 24 cycles starting at cycle 24.
- Live update: during digit 1 SHOW, write 7'h33 to digit 1 at edge k -> o_seg=7'h33 after edge k+1, anode unchanged, slot length still 4.
- Out-of-range write: NUM_DIGITS=3, i_wr_digit=3, i_seg=7'h7F -> no buffer entry changes; scan shows prior values.
- Enable drop: deassert i_enable during cycle 2 of digit 2 SHOW -> all anodes off, o_seg=0 next cycle, o_digit_idx stays 2. Re-assert -> 2 blank cycles, then digit 2 shown for 4 full cycles, then digit 3.
- No-blank mode: BLANK_CYCLES=0 -> anode steps 1110->1101->1011->0111 every 4 cycles with no all-off cycle; frame 16 cycles, o_frame_done every 16 cycles.
